// File: rtl/conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// conv_window_sequencer
//
// Controller for an external parallel array of NTAP = KERNEL_SIZE^2 signed
// Q8.8 multipliers. It loads a weight bank serially and takes whole pixel
// windows. For each window it presents both operand banks to the multiplier
// and captures the products. It then reduces them one tap per clock in a
// wide accumulator and emits one saturated Q8.8 sample.
//
// Optional build macro:
//   CONV_SEQ_RELU_EN  - clamp negative (saturated) results to 0x0000.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   wt_data/valid   serial weight word, tap order 0..NTAP-1
//   wt_ready        high while the weight bank is being loaded
//   reload          one-cycle pulse in IDLE: discard weights, reload them
//   win_data/valid  pixel window, tap j at [j*DATA_WIDTH +: DATA_WIDTH]
//   win_ready       high only in IDLE
//   mult_weights    registered weight bank to the multiplier
//   mult_pixels     registered pixel bank to the multiplier
//   mult_result     per-tap products from the multiplier (Q8.8)
//   conv_out/valid  convolution result, held until conv_ready
//   conv_ready      downstream accepts conv_out
//   weights_loaded  bank holds a complete weight set
//   busy            high in MULT, ACC and OUT
//   state_dbg       current FSM state encoding
//
// Handshake rule for every valid/ready pair in this block: a transfer
// happens on a rising clk edge where valid and ready are both high. A
// producer holds valid and its data stable until that edge. ready never
// depends combinationally on valid.
// ---------------------------------------------------------------------------
module conv_window_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DATA_WIDTH-1:0]                    wt_data,
  input  logic                                     wt_valid,
  output logic                                     wt_ready,
  input  logic                                     reload,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
  input  logic                                     win_valid,
  output logic                                     win_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] mult_weights,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] mult_pixels,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] mult_result,
  output logic [DATA_WIDTH-1:0]                    conv_out,
  output logic                                     conv_valid,
  input  logic                                     conv_ready,
  output logic                                     weights_loaded,
  output logic                                     busy,
  output logic [2:0]                               state_dbg
);

  localparam int NTAP  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int IDX_W = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int ACC_W = DATA_WIDTH + $clog2(NTAP);
  localparam int EXT_W = ACC_W - DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NTAP - 1);

  typedef enum logic [2:0] {
    S_LOAD_W = 3'd0,
    S_IDLE   = 3'd1,
    S_MULT   = 3'd2,
    S_ACC    = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       cnt;   // weight write pointer
  logic [IDX_W-1:0]       idx;   // accumulation pointer
  logic [ACC_W-1:0]       acc;   // two's complement running sum
  logic [DATA_WIDTH-1:0]  wt_bank  [NTAP];
  logic [DATA_WIDTH-1:0]  pix_bank [NTAP];
  logic [DATA_WIDTH-1:0]  prod     [NTAP];

  logic [DATA_WIDTH-1:0]  prod_sel;
  logic [ACC_W-1:0]       acc_next;
  logic [EXT_W:0]         acc_top;
  logic [DATA_WIDTH-1:0]  sat_val;
  logic [DATA_WIDTH-1:0]  out_val;

  assign state_dbg = state;

  // Operand banks go straight from registers to the multiplier.
  always_comb begin
    mult_weights = '0;
    mult_pixels  = '0;
    for (int j = 0; j < NTAP; j++) begin
      mult_weights[j*DATA_WIDTH +: DATA_WIDTH] = wt_bank[j];
      mult_pixels[j*DATA_WIDTH +: DATA_WIDTH]  = pix_bank[j];
    end
  end

  // Next accumulator value plus saturation of the would-be final sum.
  // The sum fits in DATA_WIDTH bits exactly when the top EXT_W+1 bits are
  // all copies of the sign bit; otherwise clamp by the true sign.
  always_comb begin
    prod_sel = prod[idx];
    acc_next = acc + {{EXT_W{prod_sel[DATA_WIDTH-1]}}, prod_sel};
    acc_top  = acc_next[ACC_W-1:DATA_WIDTH-1];
    if ((&acc_top) || !(|acc_top)) begin
      sat_val = acc_next[DATA_WIDTH-1:0];
    end else if (acc_next[ACC_W-1]) begin
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`ifdef CONV_SEQ_RELU_EN
    out_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
    out_val = sat_val;
`endif
  end

  // Main FSM. ready/busy flags are registered and updated together with
  // the state so they always describe the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_LOAD_W;
      cnt            <= '0;
      idx            <= '0;
      acc            <= '0;
      conv_out       <= '0;
      conv_valid     <= 1'b0;
      wt_ready       <= 1'b0;
      win_ready      <= 1'b0;
      weights_loaded <= 1'b0;
      busy           <= 1'b0;
      for (int j = 0; j < NTAP; j++) begin
        wt_bank[j]  <= '0;
        pix_bank[j] <= '0;
        prod[j]     <= '0;
      end
    end else begin
      case (state)
        S_LOAD_W: begin
          wt_ready <= 1'b1;
          if (wt_valid && wt_ready) begin
            wt_bank[cnt] <= wt_data;
            if (cnt == LAST_TAP) begin
              cnt            <= '0;
              weights_loaded <= 1'b1;
              wt_ready       <= 1'b0;
              win_ready      <= 1'b1;
              state          <= S_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_IDLE: begin
          // reload wins over a simultaneous window offer
          if (reload) begin
            weights_loaded <= 1'b0;
            cnt            <= '0;
            win_ready      <= 1'b0;
            wt_ready       <= 1'b1;
            state          <= S_LOAD_W;
          end else if (win_valid && win_ready) begin
            for (int j = 0; j < NTAP; j++) begin
              pix_bank[j] <= win_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
            win_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_MULT;
          end
        end

        // Operands have been stable for one full cycle: products are settled.
        S_MULT: begin
          for (int j = 0; j < NTAP; j++) begin
            prod[j] <= mult_result[j*DATA_WIDTH +: DATA_WIDTH];
          end
          acc   <= '0;
          idx   <= '0;
          state <= S_ACC;
        end

        S_ACC: begin
          acc <= acc_next;
          if (idx == LAST_TAP) begin
            idx        <= '0;
            conv_out   <= out_val;
            conv_valid <= 1'b1;
            state      <= S_OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_OUT: begin
          if (conv_ready) begin
            conv_valid <= 1'b0;
            busy       <= 1'b0;
            win_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: begin
          state      <= S_LOAD_W;
          cnt        <= '0;
          conv_valid <= 1'b0;
          busy       <= 1'b0;
          win_ready  <= 1'b0;
          wt_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
module tb_conv_window_sequencer;

  localparam int DW   = 16;
  localparam int KS   = 5;
  localparam int NTAP = KS * KS;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [DW-1:0]        wt_data;
  logic                 wt_valid;
  logic                 wt_ready;
  logic                 reload;
  logic [NTAP*DW-1:0]   win_data;
  logic                 win_valid;
  logic                 win_ready;
  logic [NTAP*DW-1:0]   mult_weights;
  logic [NTAP*DW-1:0]   mult_pixels;
  logic [NTAP*DW-1:0]   mult_result;
  logic [DW-1:0]        conv_out;
  logic                 conv_valid;
  logic                 conv_ready;
  logic                 weights_loaded;
  logic                 busy;
  logic [2:0]           state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] tw[NTAP];
  logic [DW-1:0] tp[NTAP];

  conv_window_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS)) dut (
    .clk(clk), .rst_n(rst_n),
    .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
    .reload(reload),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .mult_weights(mult_weights), .mult_pixels(mult_pixels),
    .mult_result(mult_result),
    .conv_out(conv_out), .conv_valid(conv_valid), .conv_ready(conv_ready),
    .weights_loaded(weights_loaded), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- multiplier model (environment) ----------------
  function automatic logic [DW-1:0] qmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

  always_comb begin
    mult_result = '0;
    for (int j = 0; j < NTAP; j++)
      mult_result[j*DW +: DW] = qmul(mult_weights[j*DW +: DW], mult_pixels[j*DW +: DW]);
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_conv();
    int s;
    logic [DW-1:0] r;
    s = 0;
    for (int j = 0; j < NTAP; j++) s += int'($signed(qmul(tw[j], tp[j])));
    if (s > 32767)       r = 16'h7FFF;
    else if (s < -32768) r = 16'h8000;
    else                 r = s[DW-1:0];
`ifdef CONV_SEQ_RELU_EN
    if (r[DW-1]) r = 16'h0000;
`endif
    return r;
  endfunction

  function automatic logic [NTAP*DW-1:0] pack_win();
    logic [NTAP*DW-1:0] v;
    for (int j = 0; j < NTAP; j++) v[j*DW +: DW] = tp[j];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_weights();
    int t;
    for (int j = 0; j < NTAP; j++) begin
      wt_data  = tw[j];
      wt_valid = 1'b1;
      t = 0;
      while (!wt_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) begin
        n_checks++; n_fail++;
        $display("FAIL wt_ready_timeout tap %0d: wt_ready=%b required 1", j, wt_ready);
      end
      if (j == NTAP - 1) begin
        n_checks++;
        if (weights_loaded !== 1'b0) begin
          n_fail++;
          $display("FAIL loaded_early: weights_loaded=%b required 0", weights_loaded);
        end
      end
      @(negedge clk);
    end
    wt_valid = 1'b0;
    n_checks++;
    if (weights_loaded !== 1'b1 || win_ready !== 1'b1 || wt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done: loaded=%b win_ready=%b wt_ready=%b required 1 1 0",
               weights_loaded, win_ready, wt_ready);
    end
  endtask

  task automatic reload_weights();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    load_weights();
  endtask

  // Pop the expected result and compare it over 'hold' stalled cycles plus
  // the handshake cycle, then check the return to IDLE.
  task automatic collect(input int hold);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: conv_out=%h with nothing expected", conv_out);
      e = 'x;
    end else begin
      e = exp_q.pop_front();
    end
    for (int h = 0; h < hold; h++) begin
      n_checks++;
      if (conv_out !== e || conv_valid !== 1'b1 || win_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_%0d: out=%h valid=%b win_ready=%b busy=%b required %h 1 0 1",
                 h, conv_out, conv_valid, win_ready, busy, e);
      end
      @(negedge clk);
    end
    n_checks++;
    if (conv_out !== e) begin
      n_fail++;
      $display("FAIL conv_out: got %h required %h", conv_out, e);
    end
    conv_ready = 1'b1;
    @(negedge clk);
    conv_ready = 1'b0;
    n_checks++;
    if (conv_valid !== 1'b0 || win_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release: valid=%b win_ready=%b busy=%b required 0 1 0",
               conv_valid, win_ready, busy);
    end
  endtask

  // Offer tp as a window; optionally disturb with reload/wt_valid in ACC.
  task automatic send_window(input int hold, input bit disturb);
    int t, lat;
    win_data  = pack_win();
    win_valid = 1'b1;
    t = 0;
    while (!win_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL win_ready_timeout: win_ready=%b required 1", win_ready);
    end
    exp_q.push_back(model_conv());
    @(negedge clk);
    win_valid = 1'b0;
    lat = 0;
    while (!conv_valid && lat < 100) begin
      if (disturb && lat == 5) begin
        reload = 1'b1; wt_valid = 1'b1; wt_data = DW'($urandom_range(0, 65535));
      end else begin
        reload = 1'b0; wt_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    reload = 1'b0; wt_valid = 1'b0;
    n_checks++;
    if (lat != NTAP + 1) begin
      n_fail++;
      $display("FAIL latency: got %0d edges required %0d", lat, NTAP + 1);
    end
    if (disturb) begin
      n_checks++;
      if (weights_loaded !== 1'b1) begin
        n_fail++;
        $display("FAIL reload_ignored: weights_loaded=%b required 1", weights_loaded);
      end
    end
    if (conv_valid) collect(hold);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    wt_data = '0; wt_valid = 1'b0; reload = 1'b0;
    win_data = '0; win_valid = 1'b0; conv_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (conv_out !== '0 || conv_valid !== 1'b0 || win_ready !== 1'b0 ||
        weights_loaded !== 1'b0 || busy !== 1'b0 ||
        mult_weights !== '0 || mult_pixels !== '0) begin
      n_fail++;
      $display("FAIL reset_values: out=%h valid=%b win_ready=%b loaded=%b busy=%b",
               conv_out, conv_valid, win_ready, weights_loaded, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wt_ready !== 1'b1 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: wt_ready=%b state=%0d required 1 0", wt_ready, state_dbg);
    end
  endtask

  task automatic test_basic();
    foreach (tw[j]) tw[j] = 16'h0100;
    foreach (tp[j]) tp[j] = 16'h0100;
    load_weights();
    send_window(0, 1'b0);
  endtask

  task automatic test_pos_sat();
    foreach (tw[j]) tw[j] = 16'h0400;
    foreach (tp[j]) tp[j] = 16'h0400;
    reload_weights();
    send_window(0, 1'b0);
  endtask

  task automatic test_neg_sat();
    foreach (tw[j]) tw[j] = 16'hFC00;
    foreach (tp[j]) tp[j] = 16'h0400;
    reload_weights();
    send_window(0, 1'b0);
  endtask

  task automatic test_backpressure();
    foreach (tw[j]) tw[j] = DW'($urandom_range(0, 1023));
    foreach (tp[j]) tp[j] = DW'($urandom_range(0, 1023));
    reload_weights();
    send_window(5, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen;
    foreach (tp[j]) tp[j] = 16'h0200;
    win_data  = pack_win();
    win_valid = 1'b1;
    @(negedge clk);             // edge 0: accepted (already in IDLE)
    win_valid = 1'b0;
    repeat (11) @(negedge clk); // edges 1..11: idx now 10
    n_checks++;
    if (state_dbg !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_state: state=%0d required 3", state_dbg);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (conv_out !== '0 || conv_valid !== 1'b0 || win_ready !== 1'b0 ||
        weights_loaded !== 1'b0 || busy !== 1'b0 || mult_pixels !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: out=%h valid=%b win_ready=%b loaded=%b busy=%b",
               conv_out, conv_valid, win_ready, weights_loaded, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (conv_valid) seen++;
      if (c == 0) begin
        n_checks++;
        if (wt_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL mid_release: wt_ready=%b required 1", wt_ready);
        end
      end
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL no_partial: conv_valid high %0d cycles required 0", seen);
    end
  endtask

  task automatic test_reload();
    foreach (tw[j]) tw[j] = 16'h0100;
    load_weights();
    foreach (tp[j]) tp[j] = 16'h0300;
    win_data  = pack_win();
    win_valid = 1'b1;
    reload    = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
    reload    = 1'b0;
    n_checks++;
    if (weights_loaded !== 1'b0 || wt_ready !== 1'b1 || win_ready !== 1'b0 ||
        busy !== 1'b0 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reload_priority: loaded=%b wt_ready=%b win_ready=%b busy=%b state=%0d",
               weights_loaded, wt_ready, win_ready, busy, state_dbg);
    end
    foreach (tw[j]) tw[j] = DW'($urandom_range(0, 2047) - 1024);
    load_weights();
    send_window(0, 1'b1);
    send_window(0, 1'b0);  // weight bank must be untouched by the ignored wt_valid
  endtask

  task automatic test_random();
    foreach (tw[j]) tw[j] = DW'($urandom_range(0, 65535));
    reload_weights();
    for (int k = 0; k < 4; k++) begin
      foreach (tp[j]) tp[j] = DW'($urandom_range(0, 65535));
      send_window($urandom_range(0, 2), 1'b0);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_sat();
    test_backpressure();
    test_reset_mid();
    test_reload();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
